data_ram_ctrl: RTL and testbench



---
 rtl/data_ram_pkg.sv | 34 +++
 rtl/data_ram_ctrl_if.sv | 26 ++
 rtl/data_ram_lane_align.sv | 80 ++++++++
 rtl/data_ram_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_ram_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared encodings for the MEM-stage data RAM controller
package data_ram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_ALIGN = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_SIZE  = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        WAIT   = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// rtl/data_ram_ctrl_if.sv - request/response bus between the MEM stage and the data RAM
interface data_ram_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [1:0]        rsp_err_code;

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
    );
endinterface

// File: rtl/data_ram_lane_align.sv
// rtl/data_ram_lane_align.sv - access checking, big-endian lane steering and load extension
module data_ram_lane_align
    import data_ram_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 64
) (
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rd_word,
    output logic [1:0]        err_code,
    output logic [3:0]        wr_en,
    output logic [31:0]       wr_word,
    output logic [31:0]       rdata
);

    // Two spare bits keep addr + nbytes exact even at the very top of the address space.
    localparam logic [ADDR_W+1:0] DEPTH_LIM = (ADDR_W+2)'(DEPTH_BYTES);

    logic [1:0]        off;
    logic [ADDR_W+1:0] end_addr;
    logic [3:0]        lane_en;
    logic [31:0]       ext;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign off      = addr[1:0];
    assign end_addr = {2'b00, addr} + {{(ADDR_W-1){1'b0}}, size_bytes(size)};

    always_comb begin
        err_code = ERR_NONE;
        if (size == SZ_BAD)
            err_code = ERR_SIZE;
        else if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && off != 2'b00))
            err_code = ERR_ALIGN;
        else if (end_addr > DEPTH_LIM)
            err_code = ERR_RANGE;
    end

    // Bit k of lane_en selects byte offset k, which sits in word bits [31-8k -: 8].
    always_comb begin
        lane_en = 4'b0000;
        wr_word = 32'h0;
        ext     = 32'h0;
        case (off)
            2'd0:    ld_byte = rd_word[31:24];
            2'd1:    ld_byte = rd_word[23:16];
            2'd2:    ld_byte = rd_word[15:8];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = off[1] ? rd_word[15:0] : rd_word[31:16];
        case (size)
            SZ_BYTE: begin
                lane_en = 4'b0001 << off;
                wr_word = {4{wdata[7:0]}};
                ext     = {{24{sign & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                lane_en = off[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata[15:0]}};
                ext     = {{16{sign & ld_half[15]}}, ld_half};
            end
            SZ_WORD: begin
                lane_en = 4'b1111;
                wr_word = wdata;
                ext     = rd_word;
            end
            default: begin
                lane_en = 4'b0000;
            end
        endcase
    end

    assign wr_en = (we && err_code == ERR_NONE) ? lane_en : 4'b0000;
    assign rdata = (!we && err_code == ERR_NONE) ? ext : 32'h0;

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - byte-addressed big-endian data memory with valid/ready request and pulse response
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DEPTH_BYTES    = 64,
    parameter int WAIT_CYCLES    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic            clk,
    input logic            rst,
    data_ram_ctrl_if.slave bus
);

    localparam int               WORDS     = DEPTH_BYTES / 4;
    localparam int               IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
    localparam logic [2:0]       WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    state_e            state;
    logic [IDX_W-1:0]  clr_ptr;
    logic [2:0]        wait_cnt;

    logic              c_we;
    logic [1:0]        c_size;
    logic              c_sign;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;

    logic [31:0]       acc_rdata;
    logic [1:0]        acc_code;

    logic [31:0]       mem [WORDS];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic [1:0]        err_code;
    logic [3:0]        wr_en;
    logic [31:0]       wr_word;
    logic [31:0]       ld_rdata;

    assign idx     = c_addr[IDX_W+1:2];
    assign rd_word = mem[idx];

    data_ram_lane_align #(
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_align (
        .size     (c_size),
        .sign     (c_sign),
        .we       (c_we),
        .addr     (c_addr),
        .wdata    (c_wdata),
        .rd_word  (rd_word),
        .err_code (err_code),
        .wr_en    (wr_en),
        .wr_word  (wr_word),
        .rdata    (ld_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= INIT;
            clr_ptr          <= '0;
            wait_cnt         <= 3'd0;
            c_we             <= 1'b0;
            c_size           <= 2'b00;
            c_sign           <= 1'b0;
            c_addr           <= '0;
            c_wdata          <= 32'h0;
            acc_rdata        <= 32'h0;
            acc_code         <= ERR_NONE;
            bus.req_ready    <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= 32'h0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_err_code <= ERR_NONE;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                INIT: begin
                    if (CLEAR_ON_RESET == 0 || clr_ptr == LAST_IDX) begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid) begin
                        c_we          <= bus.req_we;
                        c_size        <= bus.req_size;
                        c_sign        <= bus.req_sign;
                        c_addr        <= bus.req_addr;
                        c_wdata       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0)
                        state <= ACCESS;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                ACCESS: begin
                    acc_rdata <= ld_rdata;
                    acc_code  <= err_code;
                    state     <= RESP;
                end
                RESP: begin
                    // Outputs are published together so the previous response stays intact until now.
                    bus.rsp_valid    <= 1'b1;
                    bus.rsp_rdata    <= acc_rdata;
                    bus.rsp_err      <= (acc_code != ERR_NONE);
                    bus.rsp_err_code <= acc_code;
                    bus.req_ready    <= 1'b1;
                    state            <= IDLE;
                end
                default: begin
                    state         <= INIT;
                    clr_ptr       <= '0;
                    bus.req_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT && CLEAR_ON_RESET != 0) begin
                mem[clr_ptr] <= 32'h0;
            end else if (state == ACCESS) begin
                for (int k = 0; k < 4; k++) begin
                    if (wr_en[k])
                        mem[idx][31-8*k -: 8] <= wr_word[31-8*k -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - randomized and directed checks of data_ram_ctrl against a byte-array model
module tb_data_ram_ctrl;

    bit   clk = 1'b0;
    logic rst0, rst1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] model [64];

    always #5 clk = ~clk;

    data_ram_ctrl_if #(.ADDR_W(32)) if0 ();
    data_ram_ctrl_if #(.ADDR_W(32)) if1 ();

    data_ram_ctrl #(.ADDR_W(32), .DEPTH_BYTES(64), .WAIT_CYCLES(0), .CLEAR_ON_RESET(1))
        dut0 (.clk(clk), .rst(rst0), .bus(if0));
    data_ram_ctrl #(.ADDR_W(32), .DEPTH_BYTES(64), .WAIT_CYCLES(3), .CLEAR_ON_RESET(0))
        dut1 (.clk(clk), .rst(rst1), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int d, input logic v, input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_size = sz;
            if0.req_sign = sg; if0.req_addr = a; if0.req_wdata = wd;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
            if1.req_sign = sg; if1.req_addr = a; if1.req_wdata = wd;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? if0.req_ready : if1.req_ready;
    endfunction

    function automatic logic vld(input int d);
        return (d == 0) ? if0.rsp_valid : if1.rsp_valid;
    endfunction

    function automatic logic [34:0] rsp(input int d);
        return (d == 0) ? {if0.rsp_rdata, if0.rsp_err, if0.rsp_err_code}
                        : {if1.rsp_rdata, if1.rsp_err, if1.rsp_err_code};
    endfunction

    function automatic int ref_err(input int sz, input logic [31:0] a);
        longint n, aa;
        if (sz == 3) return 3;
        n  = longint'(1) << sz;
        aa = {32'h0, a};
        if (aa % n != 0) return 1;
        if (aa + n > 64) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input int sz, input logic sg, input logic [31:0] a);
        longint v, n;
        n = longint'(1) << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(model[int'(a) + i]);
        if (sg && sz < 2 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic do_reset(input int d, input int exp_init);
        int cnt;
        logic seen;
        if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
        set_req(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | vld(d);
        end
        check($sformatf("rst%0d_ready", d), 32'(rdy(d)), 32'h0);
        check($sformatf("rst%0d_rsp", d), 32'(rsp(d)), 32'h0);
        if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
        cnt = 0;
        while (!rdy(d) && cnt < 100) begin
            seen = seen | vld(d);
            cnt++;
            @(negedge clk);
        end
        check($sformatf("rst%0d_init_cycles", d), 32'(cnt), 32'(exp_init));
        check($sformatf("rst%0d_no_rsp", d), 32'(seen), 32'h0);
    endtask

    task automatic access(input int d, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output logic [1:0] code,
                          output int lat);
        int n;
        @(negedge clk);
        set_req(d, 1'b1, we, sz, sg, a, wd);
        n = 0;
        while (!rdy(d) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_bound", 32'(n < 200), 32'h1);
        @(posedge clk);
        @(negedge clk);
        set_req(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        lat = 0;
        while (!vld(d) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        {rd, err, code} = rsp(d);
        @(negedge clk);
        check("rsp_one_cycle", 32'(vld(d)), 32'h0);
    endtask

    task automatic op0(input string tag, input logic we, input int sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic        err;
        logic [1:0]  code;
        int          lat, ecode, n;
        logic [31:0] erd;
        ecode = ref_err(sz, a);
        erd   = (ecode == 0 && !we) ? ref_load(sz, sg, a) : 32'h0;
        access(0, we, 2'(sz), sg, a, wd, rd, err, code, lat);
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_err"}, 32'(err), 32'(ecode != 0));
        check({tag, "_code"}, 32'(code), 32'(ecode));
        check({tag, "_lat"}, 32'(lat), 32'd2);
        if (ecode == 0 && we) begin
            n = 1 << sz;
            for (int i = 0; i < n; i++) model[int'(a) + i] = wd[8*(n-1-i) +: 8];
        end
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        err;
        logic [1:0]  code;
        int          lat, first_rdy, r, sz;
        int          rsp_k [$];
        logic [31:0] rsp_d [$];

        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        rst0 = 1'b1;
        rst1 = 1'b1;
        set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        do_reset(0, 16);
        do_reset(1, 1);

        op0("ld_w0", 1'b0, 2, 1'b0, 32'd0, 32'h0, rd);   check("clr_w0", rd, 32'h0);
        op0("ld_w60", 1'b0, 2, 1'b0, 32'd60, 32'h0, rd); check("clr_w60", rd, 32'h0);

        op0("st_w8", 1'b1, 2, 1'b0, 32'd8, 32'hDEADBEEF, rd);
        op0("ld_b8", 1'b0, 0, 1'b0, 32'd8, 32'h0, rd);   check("b8", rd, 32'h000000DE);
        op0("ld_b9", 1'b0, 0, 1'b0, 32'd9, 32'h0, rd);   check("b9", rd, 32'h000000AD);
        op0("ld_b10", 1'b0, 0, 1'b0, 32'd10, 32'h0, rd); check("b10", rd, 32'h000000BE);
        op0("ld_b11", 1'b0, 0, 1'b0, 32'd11, 32'h0, rd); check("b11", rd, 32'h000000EF);
        op0("ld_sb8", 1'b0, 0, 1'b1, 32'd8, 32'h0, rd);  check("sb8", rd, 32'hFFFFFFDE);
        op0("ld_sh10", 1'b0, 1, 1'b1, 32'd10, 32'h0, rd); check("sh10", rd, 32'hFFFFBEEF);

        op0("st_w4", 1'b1, 2, 1'b0, 32'd4, 32'hAABBCCDD, rd);
        op0("st_h6", 1'b1, 1, 1'b0, 32'd6, 32'h00001234, rd);
        op0("ld_w4", 1'b0, 2, 1'b0, 32'd4, 32'h0, rd);   check("w4_merge", rd, 32'hAABB1234);

        op0("err_w2", 1'b0, 2, 1'b0, 32'd2, 32'h0, rd);
        op0("err_st62", 1'b1, 2, 1'b0, 32'd62, 32'h11111111, rd);
        op0("err_st64", 1'b1, 2, 1'b0, 32'd64, 32'h22222222, rd);
        op0("err_sz3", 1'b0, 3, 1'b0, 32'd1, 32'h0, rd);
        op0("err_top", 1'b0, 2, 1'b0, 32'hFFFFFFFC, 32'h0, rd);
        op0("ld_w60b", 1'b0, 2, 1'b0, 32'd60, 32'h0, rd); check("w60_untouched", rd, 32'h0);

        for (int t = 0; t < 80; t++) begin
            r  = $urandom_range(0, 9);
            sz = $urandom_range(0, 3);
            if (r < 8) a = 32'($urandom_range(0, 67));
            else if (r == 8) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = $urandom;
            if (r < 6 && sz < 3) a = a & ~((32'h1 << sz) - 32'h1);
            op0($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                a, $urandom, rd);
        end

        access(1, 1'b1, 2'b10, 1'b0, 32'd20, 32'h11223344, rd, err, code, lat);
        check("w3_st_lat", 32'(lat), 32'd5);
        check("w3_st_err", 32'(err), 32'h0);

        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'd24, 32'hCAFEF00D);
        r = 0;
        while (!if1.req_ready && r < 50) begin
            @(negedge clk);
            r++;
        end
        check("w3_b2b_accept", 32'(r < 50), 32'h1);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd24, 32'h0);
        first_rdy = -1;
        for (int k = 0; k < 15; k++) begin
            if (first_rdy >= 0 && k == first_rdy + 1) if1.req_valid = 1'b0;
            if (first_rdy < 0 && if1.req_ready) first_rdy = k;
            if (if1.rsp_valid) begin
                rsp_k.push_back(k);
                rsp_d.push_back(if1.rsp_rdata);
            end
            @(negedge clk);
        end
        check("w3_b2b_first_ready", 32'(first_rdy), 32'd5);
        check("w3_b2b_rsp_count", 32'(rsp_k.size()), 32'd2);
        if (rsp_k.size() == 2) begin
            check("w3_b2b_rsp0_cycle", 32'(rsp_k[0]), 32'd5);
            check("w3_b2b_rsp1_cycle", 32'(rsp_k[1]), 32'd11);
            check("w3_b2b_rsp1_data", rsp_d[1], 32'hCAFEF00D);
        end

        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'd20, 32'h55667788);
        r = 0;
        while (!if1.req_ready && r < 50) begin
            @(negedge clk);
            r++;
        end
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        do_reset(1, 1);
        access(1, 1'b0, 2'b10, 1'b0, 32'd20, 32'h0, rd, err, code, lat);
        check("w3_rst_old_data", rd, 32'h11223344);
        check("w3_rst_ld_lat", 32'(lat), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
